// File: rtl/move_pkg.sv
// Shared constants, state encoding and helpers for the move_repeat direction controller.
package move_pkg;

   localparam logic [3:0] DIR_NONE       = 4'b0000;
   localparam logic [3:0] DIR_UP         = 4'b0001;
   localparam logic [3:0] DIR_DOWN       = 4'b0010;
   localparam logic [3:0] DIR_LEFT       = 4'b0100;
   localparam logic [3:0] DIR_RIGHT      = 4'b1000;
   localparam logic [3:0] DIR_UP_LEFT    = DIR_UP   | DIR_LEFT;
   localparam logic [3:0] DIR_UP_RIGHT   = DIR_UP   | DIR_RIGHT;
   localparam logic [3:0] DIR_DOWN_LEFT  = DIR_DOWN | DIR_LEFT;
   localparam logic [3:0] DIR_DOWN_RIGHT = DIR_DOWN | DIR_RIGHT;

   localparam int unsigned STATE_W = 2;
   localparam logic [STATE_W-1:0] ST_IDLE  = 2'd0;
   localparam logic [STATE_W-1:0] ST_PRESS = 2'd1;
   localparam logic [STATE_W-1:0] ST_HOLD  = 2'd2;

   // Opposing buttons cancel each other; diagonals pass through.
   function automatic logic [3:0] mask_opposing(input logic [3:0] d);
      logic [3:0] r;
      r = d;
      if (d[0] && d[1]) r[1:0] = 2'b00;
      if (d[2] && d[3]) r[3:2] = 2'b00;
      return r;
   endfunction

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/move_debounce.sv
// Two-flop synchroniser followed by a stability-run debouncer on the 4 button lines.
module move_debounce
   import move_pkg::*;
#(
   parameter int unsigned DEB_CYC = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] move,
   output logic [3:0] move_db
);

   localparam int unsigned RUN_W = $clog2(DEB_CYC + 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEB_CYC);

   logic [3:0]       sync1_q, sync1_d;
   logic [3:0]       sync2_q, sync2_d;
   logic [3:0]       prev_q, prev_d;
   logic [RUN_W-1:0] run_q, run_d;
   logic [3:0]       move_db_q, move_db_d;

   // run counts consecutive cycles the synchronised value has held, including this one
   always_comb begin
      sync1_d   = move;
      sync2_d   = sync1_q;
      prev_d    = sync2_q;
      run_d     = run_q;
      move_db_d = move_db_q;
      if (sync2_q != prev_q) begin
         run_d = RUN_W'(1);
      end else if (run_q != RUN_MAX) begin
         run_d = run_q + RUN_W'(1);
      end
      if (run_d == RUN_MAX) begin
         move_db_d = sync2_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         prev_q    <= '0;
         run_q     <= '0;
         move_db_q <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         prev_q    <= prev_d;
         run_q     <= run_d;
         move_db_q <= move_db_d;
      end
   end

   assign move_db = move_db_q;

endmodule

// File: rtl/move_repeat.sv
// Button-to-direction controller: debounce, opposing-pair mask, tap pulse and hold/repeat FSM.
module move_repeat
   import move_pkg::*;
#(
   parameter int unsigned DEB_CYC     = 1_000_000,
   parameter int unsigned HOLD_CYC    = 200_000_000,
   parameter int unsigned REPEAT_MODE = 0,
   parameter int unsigned REPEAT_CYC  = 10_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] move,
   output logic [3:0] direction,
   output logic       push_all
);

   localparam int unsigned CNT_W = $clog2(max3(DEB_CYC, HOLD_CYC, REPEAT_CYC) + 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] RPT_LAST  = CNT_W'(REPEAT_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;

   logic [3:0]         move_db;
   logic [3:0]         dir_in;
   logic [STATE_W-1:0] state_q, state_d;
   logic [CNT_W-1:0]   hcnt_q, hcnt_d;
   logic [CNT_W-1:0]   rcnt_q, rcnt_d;
   logic [3:0]         dir_reg_q, dir_reg_d;
   logic [3:0]         direction_q, direction_d;
   logic               push_all_q, push_all_d;

   move_debounce #(.DEB_CYC(DEB_CYC)) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .move    (move),
      .move_db (move_db)
   );

   assign dir_in = mask_opposing(move_db);

   always_comb begin
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      rcnt_d      = rcnt_q;
      dir_reg_d   = dir_reg_q;
      direction_d = DIR_NONE;
      push_all_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            hcnt_d = '0;
            if (dir_in != DIR_NONE) begin
               dir_reg_d   = dir_in;
               direction_d = dir_in;
               state_d     = ST_PRESS;
            end
         end
         ST_PRESS: begin
            if (dir_in == DIR_NONE) begin
               state_d = ST_IDLE;
               hcnt_d  = '0;
            end else if (dir_in != dir_reg_q) begin
               dir_reg_d   = dir_in;
               direction_d = dir_in;
               hcnt_d      = '0;
            end else if (hcnt_q == HOLD_LAST) begin
               state_d     = ST_HOLD;
               rcnt_d      = '0;
               push_all_d  = 1'b1;
               direction_d = (REPEAT_MODE != 0) ? dir_reg_q : dir_in;
            end else if (hcnt_q != CNT_MAX) begin
               hcnt_d = hcnt_q + CNT_W'(1);
            end
         end
         ST_HOLD: begin
            if (dir_in == DIR_NONE) begin
               state_d = ST_IDLE;
               hcnt_d  = '0;
               rcnt_d  = '0;
            end else begin
               push_all_d = 1'b1;
               // A new held direction restarts the repeat period with an immediate pulse
               if (dir_in != dir_reg_q) begin
                  dir_reg_d   = dir_in;
                  rcnt_d      = '0;
                  direction_d = dir_in;
               end else if (REPEAT_MODE == 0) begin
                  direction_d = dir_in;
               end else if (rcnt_q == RPT_LAST) begin
                  rcnt_d      = '0;
                  direction_d = dir_reg_q;
               end else if (rcnt_q != CNT_MAX) begin
                  rcnt_d = rcnt_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         hcnt_q      <= '0;
         rcnt_q      <= '0;
         dir_reg_q   <= DIR_NONE;
         direction_q <= DIR_NONE;
         push_all_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         rcnt_q      <= rcnt_d;
         dir_reg_q   <= dir_reg_d;
         direction_q <= direction_d;
         push_all_q  <= push_all_d;
      end
   end

   assign direction = direction_q;
   assign push_all  = push_all_q;

endmodule
